tone_arbiter: RTL and testbench

Shares the single square-wave speaker output among several requesters, such as the alarm, keyclick and melody engines. Each requester asks for a tone (half-period in clocks, duration in milliseconds) with a level request. The block grants one requester at a time in round-robin order, plays that tone for exactly the requested duration, then pulses done and inserts a silent gap. It sits between the sound sources and the board speaker pin.

---
 rtl/sound_pkg.sv | 19 +
 rtl/tone_arbiter_tone_gen.sv | 33 +++
 rtl/tone_arbiter.sv | 160 ++++++++++++++++
 tb/tb_tone_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Types and constants shared by the sound subsystem: arbiter states and field widths.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int CLK_HZ = 25_000_000;
  localparam int HP_W   = 16;
  localparam int DUR_W  = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tone_arbiter_tone_gen.sv
// Square-wave divider: toggles its output every half_period clocks while enabled.
module tone_gen
  import sound_pkg::*;
(
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic            i_En,
  input  logic [HP_W-1:0] i_Half_Period,
  output logic            o_Out
);

  logic [HP_W-1:0] cnt_reg;
  logic            out_reg;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n || !i_En) begin
      cnt_reg <= '0;
      out_reg <= 1'b0;
    end else if (i_Half_Period == '0) begin
      // A zero half-period is a rest: stay silent, never let the counter run away.
      cnt_reg <= '0;
      out_reg <= 1'b0;
    end else if (cnt_reg >= i_Half_Period - 16'd1) begin
      cnt_reg <= '0;
      out_reg <= ~out_reg;
    end else begin
      cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign o_Out = out_reg;

endmodule

// File: rtl/tone_arbiter.sv
// Round-robin owner of the speaker pin: grants one requester, plays its tone for
// the requested number of ms ticks, pulses done, then holds a silent gap.
module tone_arbiter
  import sound_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int TICK_DIV = 25000,
  parameter int GAP_MS   = 1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic [NUM_REQ-1:0]      i_Req,
  input  logic [HP_W*NUM_REQ-1:0] i_Half_Period,
  input  logic [DUR_W*NUM_REQ-1:0] i_Duration,
  output logic [NUM_REQ-1:0]      o_Grant,
  output logic [NUM_REQ-1:0]      o_Done,
  output logic                    o_Busy,
  output logic                    o_Out
);

  localparam int PTR_W = cnt_width(NUM_REQ);
  localparam int PS_W  = cnt_width(TICK_DIV);
  localparam int GAP_W = cnt_width(GAP_MS);

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);
  localparam logic [PTR_W:0]   NREQ     = (PTR_W + 1)'(NUM_REQ);

  arb_state_t          state_reg;
  logic [PTR_W-1:0]    ptr_reg;
  logic [NUM_REQ-1:0]  grant_reg;
  logic [NUM_REQ-1:0]  done_reg;
  logic [HP_W-1:0]     hp_reg;
  logic [DUR_W-1:0]    dur_cnt_reg;
  logic [PS_W-1:0]     presc_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;

  logic [HP_W-1:0]     hp_slice  [NUM_REQ];
  logic [DUR_W-1:0]    dur_slice [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign hp_slice[gi]  = i_Half_Period[gi*HP_W +: HP_W];
    assign dur_slice[gi] = i_Duration[gi*DUR_W +: DUR_W];
  end

  // Rotate the requests so bit 0 is the pointer position; the lowest set bit wins.
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 found;
  logic [PTR_W-1:0]     offset;
  logic [PTR_W:0]       win_sum;
  logic [PTR_W:0]       next_sum;
  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     ptr_after;
  logic [NUM_REQ-1:0]   win_onehot;

  assign req_dbl = {i_Req, i_Req} >> ptr_reg;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        found  = 1'b1;
        offset = PTR_W'(j);
      end
    end
  end

  assign win_sum    = {1'b0, ptr_reg} + {1'b0, offset};
  assign winner     = (win_sum >= NREQ) ? PTR_W'(win_sum - NREQ) : win_sum[PTR_W-1:0];
  assign next_sum   = {1'b0, winner} + (PTR_W + 1)'(1);
  assign ptr_after  = (next_sum >= NREQ) ? PTR_W'(next_sum - NREQ) : next_sum[PTR_W-1:0];
  assign win_onehot = NUM_REQ'(1) << winner;

  logic presc_wrap;
  logic aborted;
  logic tone_out;

  assign presc_wrap = (presc_reg == PS_LAST);
  assign aborted    = ((i_Req & grant_reg) == '0);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      grant_reg   <= '0;
      done_reg    <= '0;
      hp_reg      <= '0;
      dur_cnt_reg <= '0;
      presc_reg   <= '0;
      gap_cnt_reg <= '0;
    end else begin
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_reg   <= PLAY;
            grant_reg   <= win_onehot;
            ptr_reg     <= ptr_after;
            hp_reg      <= hp_slice[winner];
            dur_cnt_reg <= dur_slice[winner];
            presc_reg   <= '0;
          end
        end
        PLAY: begin
          if (aborted) begin
            state_reg   <= GAP;
            grant_reg   <= '0;
            presc_reg   <= '0;
            gap_cnt_reg <= '0;
          end else if (dur_cnt_reg == '0 || (presc_wrap && dur_cnt_reg == DUR_W'(1))) begin
            // Zero duration ends after a single PLAY clock; otherwise on the last tick.
            state_reg   <= GAP;
            done_reg    <= grant_reg;
            grant_reg   <= '0;
            presc_reg   <= '0;
            gap_cnt_reg <= '0;
          end else if (presc_wrap) begin
            presc_reg   <= '0;
            dur_cnt_reg <= dur_cnt_reg - DUR_W'(1);
          end else begin
            presc_reg   <= presc_reg + PS_W'(1);
          end
        end
        GAP: begin
          if (GAP_MS == 0 || (presc_wrap && gap_cnt_reg == GAP_LAST)) begin
            state_reg <= IDLE;
            presc_reg <= '0;
          end else if (presc_wrap) begin
            presc_reg   <= '0;
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end else begin
            presc_reg <= presc_reg + PS_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          grant_reg <= '0;
        end
      endcase
    end
  end

  tone_gen u_tone_gen (
    .i_Clk         (i_Clk),
    .i_Rst_n       (i_Rst_n),
    .i_En          (state_reg == PLAY),
    .i_Half_Period (hp_reg),
    .o_Out         (tone_out)
  );

  // Gating by state silences the pin on the very clock PLAY is left, mid-phase or not.
  assign o_Out   = tone_out & (state_reg == PLAY);
  assign o_Grant = grant_reg;
  assign o_Done  = done_reg;
  assign o_Busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_tone_arbiter.sv
// Directed bench for tone_arbiter with TICK_DIV = 10 and GAP_MS = 1.
module tb_tone_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] hp = '0;
  logic [31:0] dur = '0;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        out;

  int tests = 0;
  int fails = 0;

  tone_arbiter #(.NUM_REQ(4), .TICK_DIV(10), .GAP_MS(1)) dut (
    .i_Clk         (clk),
    .i_Rst_n       (rst_n),
    .i_Req         (req),
    .i_Half_Period (hp),
    .i_Duration    (dur),
    .o_Grant       (grant),
    .o_Done        (done),
    .o_Busy        (busy),
    .o_Out         (out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tone(input int k, input int h, input int d);
    hp[k*16 +: 16] = 16'(h);
    dur[k*8 +: 8]  = 8'(d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  function automatic int grant_index(input logic [3:0] g);
    int idx = -1;
    for (int b = 3; b >= 0; b--) if (g[b]) idx = b;
    return idx;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    tests++;
    if (grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0 || out !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: grant=%b done=%b busy=%b out=%b, expected all 0", grant, done, busy, out);
    end
    rst_n = 1'b1;
    req   = '0;
    tick();
    tests++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b grant=%b, expected 0 0000", busy, grant);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    logic exp_out;
    do_reset();
    set_tone(0, 3, 2);
    req = 4'b0001;
    tick();
    tests++;
    if (grant !== 4'b0001 || busy !== 1'b1) begin
      fails++;
      $display("FAIL single_grant: grant=%b busy=%b, expected 0001 1", grant, busy);
    end
    for (int k = 0; k < 20; k++) begin
      exp_out = ((k / 3) % 2) == 1;
      tests++;
      if (out !== exp_out || grant !== 4'b0001 || done !== 4'b0) begin
        fails++;
        $display("FAIL single_play k=%0d: out=%b grant=%b done=%b, expected %b 0001 0000", k, out, grant, done, exp_out);
      end
      tick();
    end
    tests++;
    if (done !== 4'b0001 || grant !== 4'b0 || out !== 1'b0) begin
      fails++;
      $display("FAIL single_done: done=%b grant=%b out=%b, expected 0001 0000 0", done, grant, out);
    end
    req = '0;
    for (int k = 0; k < 9; k++) begin
      tick();
      tests++;
      if (out !== 1'b0 || done !== 4'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL single_gap k=%0d: out=%b done=%b busy=%b, expected 0 0000 1", k, out, done, busy);
      end
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL single_gap_end: busy=%b, expected 0", busy);
    end
    $display("[TB] single tone H=3 D=2 done");
  endtask

  task automatic test_round_robin();
    int          order[$];
    logic [3:0]  prev;
    int          n_done;
    int          bad_done;
    int          multi_hot;
    int          exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < 4; k++) set_tone(k, 2, 1);
    req = 4'b1111;
    prev = '0;
    n_done = 0;
    bad_done = 0;
    multi_hot = 0;
    for (int c = 0; c < 200 && order.size() < 5; c++) begin
      tick();
      if ($countones(grant) > 1) multi_hot++;
      if (grant != 4'b0 && prev == 4'b0) begin
        order.push_back(grant_index(grant));
        $display("[TB] round-robin grant %b", grant);
      end
      if (done != 4'b0) begin
        n_done++;
        if (done !== prev) bad_done++;
      end
      prev = grant;
    end
    tests++;
    if (order.size() != 5) begin
      fails++;
      $display("FAIL rr_count: saw %0d grants, expected 5 within budget", order.size());
    end
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      tests++;
      if (order[i] != exp_order[i]) begin
        fails++;
        $display("FAIL rr_order[%0d]: got %0d, expected %0d", i, order[i], exp_order[i]);
      end
    end
    tests++;
    if (n_done != 4 || bad_done != 0) begin
      fails++;
      $display("FAIL rr_done: %0d pulses (%0d misattributed), expected 4 (0)", n_done, bad_done);
    end
    tests++;
    if (multi_hot != 0) begin
      fails++;
      $display("FAIL rr_onehot: %0d multi-hot cycles, expected 0", multi_hot);
    end
    req = '0;
  endtask

  task automatic test_fairness();
    int         order[$];
    logic [3:0] prev;
    do_reset();
    set_tone(1, 2, 0);
    set_tone(3, 2, 0);
    req = 4'b0010;
    tick();
    tests++;
    if (grant !== 4'b0010) begin
      fails++;
      $display("FAIL fair_setup: grant=%b, expected 0010", grant);
    end
    tick();
    tests++;
    if (done !== 4'b0010) begin
      fails++;
      $display("FAIL fair_setup_done: done=%b, expected 0010", done);
    end
    req = 4'b1010;
    prev = '0;
    for (int c = 0; c < 200 && order.size() < 2; c++) begin
      tick();
      if (grant != 4'b0 && prev == 4'b0) begin
        order.push_back(grant_index(grant));
        $display("[TB] fairness grant %b", grant);
      end
      prev = grant;
    end
    tests++;
    if (order.size() != 2 || order[0] != 3 || order[1] != 1) begin
      fails++;
      $display("FAIL fair_order: got %0d grants first=%0d, expected 3 then 1", order.size(), (order.size() > 0) ? order[0] : -1);
    end
    req = '0;
  endtask

  task automatic test_abort();
    do_reset();
    set_tone(2, 2, 3);
    req = 4'b0100;
    tick();
    tests++;
    if (grant !== 4'b0100) begin
      fails++;
      $display("FAIL abort_grant: grant=%b, expected 0100", grant);
    end
    tick();
    tick();
    tests++;
    if (out !== 1'b1) begin
      fails++;
      $display("FAIL abort_tone: out=%b, expected 1", out);
    end
    req = '0;
    tick();
    tests++;
    if (grant !== 4'b0 || done !== 4'b0 || out !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_edge: grant=%b done=%b out=%b busy=%b, expected 0000 0000 0 1", grant, done, out, busy);
    end
    for (int k = 0; k < 9; k++) begin
      tick();
      tests++;
      if (done !== 4'b0 || out !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL abort_gap k=%0d: done=%b out=%b busy=%b, expected 0000 0 1", k, done, out, busy);
      end
    end
    tick();
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_gap_end: busy=%b, expected 0", busy);
    end
    $display("[TB] abort of requester 2 done");
  endtask

  task automatic test_edges();
    bit ok;
    // Rest: H=0 for 5 ticks.
    do_reset();
    set_tone(0, 0, 5);
    req = 4'b0001;
    tick();
    for (int k = 0; k < 50; k++) begin
      tests++;
      if (out !== 1'b0 || grant !== 4'b0001 || done !== 4'b0) begin
        fails++;
        $display("FAIL rest_play k=%0d: out=%b grant=%b done=%b, expected 0 0001 0000", k, out, grant, done);
      end
      tick();
    end
    tests++;
    if (done !== 4'b0001 || grant !== 4'b0) begin
      fails++;
      $display("FAIL rest_done: done=%b grant=%b, expected 0001 0000", done, grant);
    end
    req = '0;
    wait_idle(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rest_idle: busy=%b after budget, expected 0", busy);
    end
    $display("[TB] rest H=0 D=5 done");

    // Zero duration: one PLAY clock.
    do_reset();
    set_tone(1, 4, 0);
    req = 4'b0010;
    tick();
    tests++;
    if (grant !== 4'b0010 || busy !== 1'b1) begin
      fails++;
      $display("FAIL d0_grant: grant=%b busy=%b, expected 0010 1", grant, busy);
    end
    tick();
    tests++;
    if (done !== 4'b0010 || grant !== 4'b0) begin
      fails++;
      $display("FAIL d0_done: done=%b grant=%b, expected 0010 0000", done, grant);
    end
    req = '0;
    tick();
    tests++;
    if (done !== 4'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL d0_pulse: done=%b busy=%b, expected 0000 1", done, busy);
    end
    $display("[TB] zero duration done");

    // H=1 toggles every clock; a half-period change during PLAY is ignored.
    do_reset();
    set_tone(0, 1, 1);
    req = 4'b0001;
    tick();
    set_tone(0, 5, 9);
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (out !== 1'(k % 2)) begin
        fails++;
        $display("FAIL h1_play k=%0d: out=%b, expected %0d", k, out, k % 2);
      end
      tick();
    end
    tests++;
    if (done !== 4'b0001 || out !== 1'b0) begin
      fails++;
      $display("FAIL h1_done: done=%b out=%b, expected 0001 0", done, out);
    end
    req = '0;
    $display("[TB] H=1 tone done");
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    set_tone(0, 2, 3);
    set_tone(1, 2, 3);
    req = 4'b0011;
    tick();
    tick();
    tick();
    tick();
    tests++;
    if (out !== 1'b1 || grant !== 4'b0001) begin
      fails++;
      $display("FAIL rmid_before: out=%b grant=%b, expected 1 0001", out, grant);
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if (out !== 1'b0 || grant !== 4'b0 || done !== 4'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rmid_reset: out=%b grant=%b done=%b busy=%b, expected 0 0000 0000 0", out, grant, done, busy);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (grant !== 4'b0001 || done !== 4'b0) begin
      fails++;
      $display("FAIL rmid_regrant: grant=%b done=%b, expected 0001 0000", grant, done);
    end
    req = '0;
    $display("[TB] reset mid-play done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_abort();
    test_edges();
    test_reset_mid_play();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
